// File: rtl/nbin_pkg.sv
// Shared definitions for the NBin stream controller: FSM states and SRAM pin levels.
package nbin_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FILL   = 2'd1,
      ST_STREAM = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // SRAM control pins are active low
   localparam logic CEN_ON  = 1'b0;
   localparam logic CEN_OFF = 1'b1;
   localparam logic WEN_WR  = 1'b0;
   localparam logic WEN_RD  = 1'b1;

endpackage

// File: rtl/nbin_out_fifo.sv
// Small synchronous FIFO holding SRAM read returns until the NFU accepts them.
module nbin_out_fifo
   import nbin_pkg::*;
#(
   parameter int WIDTH = 256,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic                       valid,
   output logic [WIDTH-1:0]           head,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic             do_pop;

   assign valid  = (count != '0);
   assign head   = mem[rd_ptr];
   assign do_pop = pop && valid;

   // Pointer and occupancy tracking; pointers wrap explicitly so any depth works
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_ONE;
         if (do_pop)
            rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_ONE;
         count <= count + CW'(push) - CW'(do_pop);
      end
   end

   // Storage needs no reset: an entry is only visible once written
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/nbin_stream_ctrl.sv
// NBin sequencer: fills the SRAM from DMA and replays address windows to the NFU.
module nbin_stream_ctrl
   import nbin_pkg::*;
#(
   parameter int N          = 256,
   parameter int ADDR       = 6,
   parameter int NUM_WORDS  = 64,
   parameter int FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_cmd_valid,
   output logic            o_cmd_ready,
   input  logic            i_cmd_write,
   input  logic [ADDR-1:0] i_cmd_base,
   input  logic [ADDR:0]   i_cmd_count,
   input  logic [7:0]      i_cmd_repeat,
   input  logic            i_fill_valid,
   output logic            o_fill_ready,
   input  logic [N-1:0]    i_fill_data,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [N-1:0]    o_data,
   output logic            o_last,
   output logic            o_done,
   output logic            o_sram_cen,
   output logic            o_sram_wen,
   output logic [ADDR-1:0] o_sram_addr,
   output logic [N-1:0]    o_sram_d,
   input  logic [N-1:0]    i_sram_q
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [ADDR:0] IDX_ONE = (ADDR + 1)'(1);
   localparam logic [ADDR:0] WORDS   = NUM_WORDS[ADDR:0];

   state_t          state;
   state_t          state_nx;
   logic [ADDR-1:0] base_q;
   logic [ADDR:0]   count_q;
   logic [7:0]      repeat_q;
   logic [ADDR:0]   last_idx;
   logic [ADDR:0]   acc_idx;
   logic [7:0]      acc_pass;
   logic            acc_done;
   logic [ADDR:0]   out_idx;
   logic [7:0]      out_pass;
   logic            inflight;
   logic [ADDR:0]   addr_sum;
   logic [ADDR:0]   addr_mod;
   logic [ADDR-1:0] acc_addr;
   logic [CW-1:0]   occ;
   logic            fill_fire;
   logic            issue;
   logic            pop;
   logic            credit_ok;
   logic            head_last;

   assign last_idx  = count_q - IDX_ONE;
   assign addr_sum  = {1'b0, base_q} + acc_idx;
   assign addr_mod  = addr_sum % WORDS;
   assign acc_addr  = addr_mod[ADDR-1:0];
   assign pop       = o_valid && i_ready;
   assign head_last = (out_idx == last_idx);
   assign o_last    = o_valid && head_last;
   // A slot freed by this cycle's pop may be reused by this cycle's read
   assign credit_ok = (int'(occ) + int'(inflight)) < (FIFO_DEPTH + int'(pop));

   nbin_out_fifo #(
      .WIDTH (N),
      .DEPTH (FIFO_DEPTH)
   ) u_out_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (inflight),
      .push_data (i_sram_q),
      .pop       (pop),
      .valid     (o_valid),
      .head      (o_data),
      .count     (occ)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ST_IDLE;
      else
         state <= state_nx;
   end

   // Next-state decode plus handshake, issue and done strobes
   always_comb begin
      state_nx     = state;
      o_cmd_ready  = 1'b0;
      o_fill_ready = 1'b0;
      o_done       = 1'b0;
      fill_fire    = 1'b0;
      issue        = 1'b0;
      case (state)
         ST_IDLE: begin
            o_cmd_ready = 1'b1;
            if (i_cmd_valid) begin
               if (i_cmd_count == '0)
                  state_nx = ST_DONE;
               else if (i_cmd_write)
                  state_nx = ST_FILL;
               else
                  state_nx = ST_STREAM;
            end
         end
         ST_FILL: begin
            o_fill_ready = 1'b1;
            fill_fire    = i_fill_valid;
            if (i_fill_valid && (acc_idx == last_idx))
               state_nx = ST_DONE;
         end
         ST_STREAM: begin
            issue = !acc_done && credit_ok;
            if (pop && head_last && (out_pass == repeat_q))
               state_nx = ST_DONE;
         end
         ST_DONE: begin
            o_done   = 1'b1;
            state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // SRAM port: parked deselected unless a write beat or read is issued this cycle
   always_comb begin
      o_sram_cen  = CEN_OFF;
      o_sram_wen  = WEN_RD;
      o_sram_addr = '0;
      o_sram_d    = '0;
      if (fill_fire) begin
         o_sram_cen  = CEN_ON;
         o_sram_wen  = WEN_WR;
         o_sram_addr = acc_addr;
         o_sram_d    = i_fill_data;
      end else if (issue) begin
         o_sram_cen  = CEN_ON;
         o_sram_addr = acc_addr;
      end
   end

   // Command capture, access-side (fill/read) and pop-side pass counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_q   <= '0;
         count_q  <= '0;
         repeat_q <= '0;
         acc_idx  <= '0;
         acc_pass <= '0;
         acc_done <= 1'b0;
         out_idx  <= '0;
         out_pass <= '0;
         inflight <= 1'b0;
      end else begin
         inflight <= issue;
         if ((state == ST_IDLE) && i_cmd_valid) begin
            base_q   <= i_cmd_base;
            count_q  <= i_cmd_count;
            repeat_q <= i_cmd_repeat;
            acc_idx  <= '0;
            acc_pass <= '0;
            acc_done <= 1'b0;
            out_idx  <= '0;
            out_pass <= '0;
         end
         if (fill_fire || issue) begin
            if (acc_idx == last_idx) begin
               acc_idx <= '0;
               if (acc_pass == repeat_q)
                  acc_done <= 1'b1;
               else
                  acc_pass <= acc_pass + 8'd1;
            end else begin
               acc_idx <= acc_idx + IDX_ONE;
            end
         end
         if (pop) begin
            if (head_last) begin
               out_idx  <= '0;
               out_pass <= out_pass + 8'd1;
            end else begin
               out_idx <= out_idx + IDX_ONE;
            end
         end
      end
   end

endmodule

// File: tb/tb_nbin_stream_ctrl.sv
// Scoreboard bench for nbin_stream_ctrl with a behavioural single-port SRAM.
module tb_nbin_stream_ctrl;

   localparam int N    = 256;
   localparam int ADDR = 6;
   localparam int NW   = 64;
   localparam int FD   = 2;

   typedef struct {
      logic [N-1:0] data;
      logic         last;
      logic         fin;
   } beat_t;

   typedef struct {
      int           addr;
      logic [N-1:0] data;
      logic         fin;
   } wr_t;

   logic            clk          = 1'b0;
   logic            rst_n        = 1'b1;
   logic            i_cmd_valid  = 1'b0;
   logic            i_cmd_write  = 1'b0;
   logic [ADDR-1:0] i_cmd_base   = '0;
   logic [ADDR:0]   i_cmd_count  = '0;
   logic [7:0]      i_cmd_repeat = '0;
   logic            i_fill_valid = 1'b0;
   logic [N-1:0]    i_fill_data  = '0;
   logic            i_ready      = 1'b1;
   logic            o_cmd_ready;
   logic            o_fill_ready;
   logic            o_valid;
   logic [N-1:0]    o_data;
   logic            o_last;
   logic            o_done;
   logic            o_sram_cen;
   logic            o_sram_wen;
   logic [ADDR-1:0] o_sram_addr;
   logic [N-1:0]    o_sram_d;
   logic [N-1:0]    i_sram_q;

   logic [N-1:0] mem     [NW];
   logic [N-1:0] ref_mem [NW];

   beat_t exp_q[$];
   int    rd_q[$];
   wr_t   wr_q[$];

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int outstanding = 0;
   logic prev_stall = 1'b0;
   logic [N-1:0] prev_data = '0;
   logic prev_last = 1'b0;
   logic done_due = 1'b0;
   logic next_due;
   wr_t   mw;
   beat_t mb;
   int    mra;

   always #5 clk = ~clk;

   nbin_stream_ctrl #(
      .N          (N),
      .ADDR       (ADDR),
      .NUM_WORDS  (NW),
      .FIFO_DEPTH (FD)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_cmd_valid  (i_cmd_valid),
      .o_cmd_ready  (o_cmd_ready),
      .i_cmd_write  (i_cmd_write),
      .i_cmd_base   (i_cmd_base),
      .i_cmd_count  (i_cmd_count),
      .i_cmd_repeat (i_cmd_repeat),
      .i_fill_valid (i_fill_valid),
      .o_fill_ready (o_fill_ready),
      .i_fill_data  (i_fill_data),
      .o_valid      (o_valid),
      .i_ready      (i_ready),
      .o_data       (o_data),
      .o_last       (o_last),
      .o_done       (o_done),
      .o_sram_cen   (o_sram_cen),
      .o_sram_wen   (o_sram_wen),
      .o_sram_addr  (o_sram_addr),
      .o_sram_d     (o_sram_d),
      .i_sram_q     (i_sram_q)
   );

   // Single-port SRAM, one-cycle read latency
   always @(posedge clk) begin
      if (!o_sram_cen) begin
         if (!o_sram_wen)
            mem[o_sram_addr] <= o_sram_d;
         else
            i_sram_q <= mem[o_sram_addr];
      end
   end

   task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   task automatic chkb(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0b, required %0b", nm, act, exp);
      end
   endtask

   task automatic note_fail(input string msg);
      checks++;
      errors++;
      $display("FAIL %s", msg);
   endtask

   function automatic logic [N-1:0] rnd_word();
      return {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Monitor: pops expected writes, reads and output words as the DUT presents them
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         rd_q.delete();
         wr_q.delete();
         outstanding = 0;
         prev_stall  = 1'b0;
         done_due    = 1'b0;
      end else begin
         next_due = 1'b0;
         chkb("done_pulse", o_done, done_due);
         if (o_done) done_cnt++;
         if (i_cmd_valid && o_cmd_ready && (i_cmd_count == '0)) next_due = 1'b1;
         if (!o_sram_cen && !o_sram_wen) begin
            if (wr_q.size() == 0)
               note_fail($sformatf("unexpected_write: got addr %0d, required no write", o_sram_addr));
            else begin
               mw = wr_q.pop_front();
               chk("write_addr", N'(o_sram_addr), N'(mw.addr));
               chk("write_data", o_sram_d, mw.data);
               if (mw.fin) next_due = 1'b1;
            end
         end
         if (!o_sram_cen && o_sram_wen) begin
            outstanding++;
            if (rd_q.size() == 0)
               note_fail($sformatf("unexpected_read: got addr %0d, required no read", o_sram_addr));
            else begin
               mra = rd_q.pop_front();
               chk("read_addr", N'(o_sram_addr), N'(mra));
            end
         end
         if (prev_stall) begin
            chkb("stall_valid", o_valid, 1'b1);
            chk("stall_data", o_data, prev_data);
            chkb("stall_last", o_last, prev_last);
         end
         if (o_valid && i_ready) begin
            outstanding--;
            if (exp_q.size() == 0)
               note_fail($sformatf("unexpected_output: got %0h, required no word", o_data));
            else begin
               mb = exp_q.pop_front();
               chk("out_data", o_data, mb.data);
               chkb("out_last", o_last, mb.last);
               if (mb.fin) next_due = 1'b1;
            end
         end
         if (!o_sram_cen && o_sram_wen) begin
            checks++;
            if (outstanding > FD) begin
               errors++;
               $display("FAIL read_ahead: got %0d reads ahead of pops, required <= %0d", outstanding, FD);
            end
         end
         prev_stall = o_valid && !i_ready;
         prev_data  = o_data;
         prev_last  = o_last;
         done_due   = next_due;
      end
   end

   task automatic do_cmd(input bit wr, input int base, input int cnt, input int rep);
      int    b;
      int    a;
      beat_t bt;
      b = 0;
      while (!o_cmd_ready && b < 200) begin
         @(posedge clk); #1;
         b++;
      end
      if (!o_cmd_ready) note_fail("cmd_ready_timeout: got 0, required 1");
      if (!wr) begin
         for (int p = 0; p <= rep; p++) begin
            for (int k = 0; k < cnt; k++) begin
               a       = (base + k) % NW;
               bt.data = ref_mem[a];
               bt.last = (k == cnt - 1);
               bt.fin  = (k == cnt - 1) && (p == rep);
               rd_q.push_back(a);
               exp_q.push_back(bt);
            end
         end
      end
      i_cmd_valid  = 1'b1;
      i_cmd_write  = wr;
      i_cmd_base   = ADDR'(base);
      i_cmd_count  = 7'(cnt);
      i_cmd_repeat = 8'(rep);
      @(posedge clk); #1;
      i_cmd_valid = 1'b0;
   endtask

   // mode 0: ready high; 1: ready 1,0,0 repeating; 2: random ready
   task automatic wait_done(input int budget, input int mode, input bit poke);
      int start;
      int cyc;
      start = done_cnt;
      cyc   = 0;
      while (done_cnt == start && cyc < budget) begin
         case (mode)
            1:       i_ready = (cyc % 3 == 0);
            2:       i_ready = 1'($urandom_range(0, 1));
            default: i_ready = 1'b1;
         endcase
         if (poke) begin
            i_cmd_valid = (cyc == 1);
            i_cmd_write = 1'b1;
            i_cmd_count = '0;
         end
         @(posedge clk); #1;
         cyc++;
      end
      i_cmd_valid = 1'b0;
      i_ready     = 1'b1;
      if (done_cnt == start)
         note_fail($sformatf("done_timeout: got no o_done in %0d cycles, required one", budget));
   endtask

   task automatic fill(input int base, input int cnt, input bit gaps, input bit fixed, input int d0);
      int           b;
      int           a;
      wr_t          w;
      logic [N-1:0] d;
      do_cmd(1'b1, base, cnt, 0);
      for (int k = 0; k < cnt; k++) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            i_fill_valid = 1'b0;
            @(posedge clk); #1;
         end
         d          = fixed ? N'(d0 + k) : rnd_word();
         a          = (base + k) % NW;
         w.addr     = a;
         w.data     = d;
         w.fin      = (k == cnt - 1);
         wr_q.push_back(w);
         ref_mem[a] = d;
         i_fill_valid = 1'b1;
         i_fill_data  = d;
         b = 0;
         while (!o_fill_ready && b < 20) begin
            @(posedge clk); #1;
            b++;
         end
         @(posedge clk); #1;
      end
      i_fill_valid = 1'b0;
      wait_done(10, 0, 1'b0);
   endtask

   task automatic stream(input int base, input int cnt, input int rep, input int mode, input bit poke);
      do_cmd(1'b0, base, cnt, rep);
      wait_done(cnt * (rep + 1) * 4 + 20, mode, poke);
   endtask

   initial begin
      int base;
      int cnt;
      int rep;
      #1 rst_n = 1'b0;
      #2;
      chkb("rst_cen", o_sram_cen, 1'b1);
      chkb("rst_wen", o_sram_wen, 1'b1);
      chk("rst_addr", N'(o_sram_addr), '0);
      chk("rst_d", o_sram_d, '0);
      chkb("rst_valid", o_valid, 1'b0);
      chkb("rst_last", o_last, 1'b0);
      chkb("rst_done", o_done, 1'b0);
      chkb("rst_fill_ready", o_fill_ready, 1'b0);
      chkb("rst_cmd_ready", o_cmd_ready, 1'b1);
      #19 rst_n = 1'b1;
      @(posedge clk); #1;

      fill(0, 4, 1'b0, 1'b1, 'hA0);
      stream(0, 4, 0, 0, 1'b1);

      fill(62, 4, 1'b0, 1'b1, 'hB0);
      stream(62, 4, 1, 0, 1'b0);

      fill(8, 8, 1'b1, 1'b0, 0);
      stream(8, 8, 0, 1, 1'b0);

      do_cmd(1'b0, 10, 0, 0);
      wait_done(10, 0, 1'b0);
      do_cmd(1'b1, 20, 0, 0);
      wait_done(10, 0, 1'b0);

      fill(5, 64, 1'b1, 1'b0, 0);
      stream(5, 64, 2, 2, 1'b0);

      for (int i = 0; i < 8; i++) begin
         base = $urandom_range(0, NW - 1);
         cnt  = $urandom_range(1, NW);
         rep  = $urandom_range(0, 3);
         if ($urandom_range(0, 2) == 0) fill(base, cnt, 1'b1, 1'b0, 0);
         stream(base, cnt, rep, $urandom_range(0, 2), 1'b0);
      end

      i_ready = 1'b1;
      do_cmd(1'b0, 0, 8, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chkb("abort_valid", o_valid, 1'b0);
      chkb("abort_cen", o_sram_cen, 1'b1);
      chkb("abort_cmd_ready", o_cmd_ready, 1'b1);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      stream(0, 4, 0, 0, 1'b0);
      stream(60, 8, 1, 1, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      chk("outputs_drained", N'(exp_q.size()), '0);
      chk("reads_drained", N'(rd_q.size()), '0);
      chk("writes_drained", N'(wr_q.size()), '0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got no completion, required finish before time limit");
      $fatal(1, "simulation time limit reached");
   end

endmodule
